// File: rtl/rda_kgp_encode_stage.sv
// rda_kgp_encode_stage: kill/propagate/generate encoder feeding a 2-entry registered FIFO.
// Define KGP_STATS_EN to add the 16-bit output-transfer counter on kgp_stats.
module rda_kgp_encode_stage #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N+1:0]   kgp_out
`ifdef KGP_STATS_EN
    ,
    output logic [15:0]      kgp_stats
`endif
);
    localparam int W = 2 * (N + 1);
    logic [W-1:0] mem [2];
    logic [W-1:0] code;
    logic [1:0]   cnt;
    logic         wr_ptr, rd_ptr, live, push, pop;
    // code bit1 = generate, bit0 = propagate-or-generate, so 2'b10 cannot occur
    always_comb begin
        code = '0;
        code[1:0] = {cin, cin};
        for (int j = 1; j <= N; j++)
            code[2*j +: 2] = {a_in[j-1] & b_in[j-1], a_in[j-1] | b_in[j-1]};
    end
    // live holds in_ready low through reset until the first clock edge after release
    assign in_ready  = live && cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign kgp_out   = out_valid ? mem[rd_ptr] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= 1'b0;
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            live   <= 1'b1;
            cnt    <= cnt + {1'b0, push} - {1'b0, pop};
            wr_ptr <= push ? ~wr_ptr : wr_ptr;
            rd_ptr <= pop ? ~rd_ptr : rd_ptr;
        end
    end
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= code;
    end
`ifdef KGP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            kgp_stats <= '0;
        else if (pop)
            kgp_stats <= kgp_stats + 16'd1;
    end
`endif
endmodule

// File: tb/tb_rda_kgp_encode_stage.sv
// tb_rda_kgp_encode_stage: scoreboard bench for the KGP encoder FIFO stage.
// Stats checks are built only when KGP_STATS_EN is defined.
module tb_rda_kgp_encode_stage;
    localparam int N = 8;
    localparam int W = 2 * (N + 1);
    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready;
    logic [N-1:0] a_in, b_in;
    logic [W-1:0] kgp_out;
    logic [W-1:0] sb [$];
    logic [W-1:0] exp_v;
    int           n_tests = 0;
    int           n_fail  = 0;
`ifdef KGP_STATS_EN
    logic [15:0]  kgp_stats;
`endif

    rda_kgp_encode_stage #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .kgp_out(kgp_out)
`ifdef KGP_STATS_EN
        , .kgp_stats(kgp_stats)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] enc(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        logic [W-1:0] r;
        r = '0;
        r[1:0] = c ? 2'b11 : 2'b00;
        for (int j = 0; j < N; j++)
            case ({a[j], b[j]})
                2'b00:   r[2*j+2 +: 2] = 2'b00;
                2'b11:   r[2*j+2 +: 2] = 2'b11;
                default: r[2*j+2 +: 2] = 2'b01;
            endcase
        return r;
    endfunction

    // scoreboard: inputs are stable at negedge, so this sees exactly what the next edge transfers
    always @(negedge clk) begin
        if (!rst_n)
            sb.delete();
        else begin
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_pop: got %h, scoreboard empty", kgp_out);
                end else begin
                    exp_v = sb.pop_front();
                    if (kgp_out !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_order: got %h, expected %h", kgp_out, exp_v);
                    end
                end
            end
            if (in_valid && in_ready)
                sb.push_back(enc(a_in, b_in, cin));
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        in_valid = v;
        a_in = a;
        b_in = b;
        cin = c;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        step;
        step;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || kgp_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ov=%b ir=%b kgp=%h, expected 0 0 0", out_valid, in_ready, kgp_out);
        end
`ifdef KGP_STATS_EN
        n_tests++;
        if (kgp_stats !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d, expected 0", kgp_stats);
        end
`endif
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, expected 0", in_ready);
        end
        step;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_edge: ir=%b ov=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_encode;
        out_ready = 1'b1;
        drive(1'b1, 8'h0F, 8'hF0, 1'b0);
        step;
        drive(1'b0, '0, '0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || kgp_out !== 18'h15554) begin
            n_fail++;
            $display("FAIL enc_prop: ov=%b kgp=%h, expected 1 15554", out_valid, kgp_out);
        end
        step;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enc_one_cycle: ov=%b, expected 0", out_valid);
        end
        drive(1'b1, 8'hFF, 8'h01, 1'b1);
        step;
        drive(1'b0, '0, '0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || kgp_out !== 18'h1555F) begin
            n_fail++;
            $display("FAIL enc_gen: ov=%b kgp=%h, expected 1 1555f", out_valid, kgp_out);
        end
        step;
    endtask

    task automatic test_full;
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        step;
        drive(1'b1, 8'h33, 8'h44, 1'b1);
        step;
        drive(1'b1, 8'h55, 8'h66, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || kgp_out !== enc(8'h11, 8'h22, 1'b0)) begin
            n_fail++;
            $display("FAIL full_block: ir=%b ov=%b kgp=%h, expected 0 1 %h", in_ready, out_valid, kgp_out, enc(8'h11, 8'h22, 1'b0));
        end
        step;
        step;
        n_tests++;
        if (in_ready !== 1'b0 || kgp_out !== enc(8'h11, 8'h22, 1'b0)) begin
            n_fail++;
            $display("FAIL full_stall: ir=%b kgp=%h, expected 0 %h", in_ready, kgp_out, enc(8'h11, 8'h22, 1'b0));
        end
        out_ready = 1'b1;
        step;
        n_tests++;
        if (in_ready !== 1'b1 || kgp_out !== enc(8'h33, 8'h44, 1'b1)) begin
            n_fail++;
            $display("FAIL full_pop1: ir=%b kgp=%h, expected 1 %h", in_ready, kgp_out, enc(8'h33, 8'h44, 1'b1));
        end
        step;
        drive(1'b0, '0, '0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || kgp_out !== enc(8'h55, 8'h66, 1'b0)) begin
            n_fail++;
            $display("FAIL full_third: ov=%b kgp=%h, expected 1 %h", out_valid, kgp_out, enc(8'h55, 8'h66, 1'b0));
        end
        step;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: ov=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_push_pop;
        out_ready = 1'b0;
        drive(1'b1, 8'hA5, 8'h5A, 1'b0);
        step;
        out_ready = 1'b1;
        drive(1'b1, 8'hC3, 8'h81, 1'b1);
        step;
        drive(1'b0, '0, '0, 1'b0);
        n_tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || kgp_out !== enc(8'hC3, 8'h81, 1'b1)) begin
            n_fail++;
            $display("FAIL push_pop: ov=%b ir=%b kgp=%h, expected 1 1 %h", out_valid, in_ready, kgp_out, enc(8'hC3, 8'h81, 1'b1));
        end
        step;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL push_pop_occ: ov=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(1'b1, 8'h12, 8'h34, 1'b1);
        step;
        drive(1'b1, 8'h56, 8'h78, 1'b0);
        step;
        drive(1'b0, '0, '0, 1'b0);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_prefill: ir=%b ov=%b, expected 0 1", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || kgp_out !== '0) begin
            n_fail++;
            $display("FAIL mid_async: ov=%b ir=%b kgp=%h, expected 0 0 0", out_valid, in_ready, kgp_out);
        end
        step;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step;
        step;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_stale: ov=%b ir=%b, expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            step;
        end
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            step;
        n_tests++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_drain: ov=%b left=%0d, expected 0 0", out_valid, sb.size());
        end
    endtask

`ifdef KGP_STATS_EN
    task automatic test_stats;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            drive(1'b1, 8'(i), 8'(3 * i), 1'b0);
            step;
            drive(1'b0, '0, '0, 1'b0);
            step;
            out_ready = 1'b1;
            step;
        end
        out_ready = 1'b0;
        step;
        step;
        n_tests++;
        if (kgp_stats !== 16'd5) begin
            n_fail++;
            $display("FAIL stats_count: got %0d, expected 5", kgp_stats);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_encode;
        test_full;
        test_push_pop;
        test_reset_mid;
        test_back_to_back;
`ifdef KGP_STATS_EN
        test_stats;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rda_kgp_encode_stage.md
RDA_KGP_ENCODE_STAGE -- requirements
Module: rda_kgp_encode_stage

Interface
REQ-001 SHALL have parameter N, default 8, operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream offers an operand set.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operand set this cycle.
REQ-006 SHALL have port a_in, input, N, operand A.
REQ-007 SHALL have port b_in, input, N, operand B.
REQ-008 SHALL have port cin, input, 1, carry-in.
REQ-009 SHALL have port out_valid, output, 1, kgp_out holds a valid code vector.
REQ-010 SHALL have port out_ready, input, 1, downstream prefix (star-operator) network accepts kgp_out.
REQ-011 SHALL have port kgp_out, output, 2*(N+1), carry-status codes, code j at bits [2j+1:2j].
REQ-012 SHALL have port kgp_stats, output, 16, transfer count, present only when KGP_STATS_EN is defined.

Function
REQ-013 SHALL encode each code as kill=2'b00, propagate=2'b01, generate=2'b11; 2'b10 never produced.
REQ-014 SHALL set code 0 to generate when cin=1, else kill.
REQ-015 SHALL set code j (1..N) from bit j-1: both 0 -> kill; exactly one 1 -> propagate; both 1 -> generate.
REQ-016 SHALL accept an input transfer on a rising edge where in_valid=1 and in_ready=1.
REQ-017 SHALL complete an output transfer on a rising edge where out_valid=1 and out_ready=1.
REQ-018 SHALL buffer accepted sets in a 2-entry FIFO of encoded vectors; storage is registered, no combinational path from inputs to kgp_out/out_valid.
REQ-019 SHALL drive in_ready=1 exactly when occupancy < 2, independent of out_ready (no pass-through when full).
REQ-020 SHALL present the earliest stored entry on kgp_out with out_valid=1 whenever occupancy > 0.
REQ-021 SHALL give latency of one cycle: set accepted on edge t appears on kgp_out after edge t when FIFO was empty.
REQ-022 SHALL keep kgp_out and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy 1 and present the new entry next cycle.
REQ-024 SHALL ignore in_valid while full; upstream must hold its data.
REQ-025 SHALL preserve strict FIFO order; pointers wrap modulo 2.
REQ-026 SHALL ignore out_ready while empty; occupancy never underflows.

Reset
REQ-027 SHALL, on rst_n low, immediately clear occupancy and pointers, forcing out_valid=0, in_ready=0 while rst_n low, kgp_out=0, kgp_stats=0.
REQ-028 SHALL drop in-flight entries when reset asserts mid-operation; in_ready returns to 1 on the first clk edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro KGP_STATS_EN defined, provide kgp_stats incrementing by 1 on each output transfer, wrapping 16'hFFFF -> 0.
REQ-030 SHALL, without KGP_STATS_EN, omit port kgp_stats and its counter; all other behaviour identical.

Verification
REQ-031 SHALL cover: N=8, a_in=8'h0F, b_in=8'hF0, cin=0, out_ready=1 -> one cycle later kgp_out code0=kill, codes1..8=propagate, out_valid=1 for one cycle.
REQ-032 SHALL cover: a_in=8'hFF, b_in=8'h01, cin=1 -> code0=generate, code1=generate, codes2..8=propagate.
REQ-033 SHALL cover: out_ready=0, three back-to-back sets -> first two accepted, in_ready=0 on third; release out_ready -> outputs in order, third accepted after first pop.
REQ-034 SHALL cover: occupancy 1, push and pop same edge -> occupancy stays 1, kgp_out shows second set.
REQ-035 SHALL cover: rst_n pulsed low with 2 entries stored -> out_valid=0 immediately, no stale entry after release.
REQ-036 SHALL cover (KGP_STATS_EN): 5 output transfers -> kgp_stats=5; stalled cycles do not increment.
